// File: rtl/c432_ctl_pkg.sv
// Purpose: shared widths, key-bit indices and query FSM states for the c432 key controller.
// Latency: none; declarations only.
// Backpressure: not applicable.
package c432_ctl_pkg;

  localparam int KEY_W   = 7;
  localparam int FRAME_W = 8;
  localparam int PI_W    = 36;
  localparam int PO_W    = 7;

  // Position of each locking input inside the 7-bit key word.
  localparam int P1 = 0;
  localparam int P2 = 1;
  localparam int P3 = 2;
  localparam int P4 = 3;
  localparam int X1 = 4;
  localparam int X2 = 5;
  localparam int X3 = 6;

  typedef enum logic [1:0] {
    Q_IDLE    = 2'd0,
    Q_SETTLE  = 2'd1,
    Q_CAPTURE = 2'd2,
    Q_RESP    = 2'd3
  } q_state_e;

  // Even parity over the whole frame (key bits plus parity bit).
  function automatic logic frame_parity_ok(input logic [FRAME_W-1:0] frame);
    return ~(^frame);
  endfunction

endpackage

// File: rtl/c432_key_shifter.sv
// Purpose: serial key frame receiver; 8-bit LSB-first frame, parity check, pending flag.
// Latency: frame_pending rises at the edge that accepts the 8th bit.
// Backpressure: key_sen ignored while a frame is pending; frame_take releases it.
// Ports: clk/rst; key_sen/key_sdi/key_clr serial input; frame_take from the owner of the
//        active key; frame_pending/frame_ok/frame_key describe the held frame.
module c432_key_shifter
  import c432_ctl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             key_sen,
  input  logic             key_sdi,
  input  logic             key_clr,
  input  logic             frame_take,
  output logic             frame_pending,
  output logic             frame_ok,
  output logic [KEY_W-1:0] frame_key
);

  logic [FRAME_W-1:0] sreg;
  logic [2:0]         bit_cnt;
  logic               pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg    <= '0;
      bit_cnt <= '0;
      pending <= 1'b0;
    end else if (pending) begin
      // A held frame is immune to key_clr and key_sen until it is consumed.
      if (frame_take) begin
        pending <= 1'b0;
        bit_cnt <= '0;
      end
    end else if (key_clr) begin
      bit_cnt <= '0;
    end else if (key_sen) begin
      // Shift right so the first (LSB) bit ends up in sreg[0] after 8 shifts.
      sreg <= {key_sdi, sreg[FRAME_W-1:1]};
      if (bit_cnt == 3'd7) begin
        pending <= 1'b1;
        bit_cnt <= '0;
      end else begin
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  assign frame_pending = pending;
  assign frame_ok      = frame_parity_ok(sreg);
  assign frame_key     = sreg[KEY_W-1:0];

endmodule

// File: rtl/c432_key_ctrl.sv
// Purpose: keys the locked c432 and runs apply/settle/capture query transactions.
// Latency: dut_in one edge after accept; r_valid rises SETTLE+1 edges after accept.
// Backpressure: q_ready low unless idle with a valid key and no pending frame; RESP holds until r_ready.
// Ports: clk/rst; key_sen/key_sdi/key_clr serial key; key_p/key_x/key_valid/key_err key state;
//        q_valid/q_ready/q_data query in; dut_in/dut_out netlist side; r_valid/r_ready/r_data
//        response out; busy while a query is in flight.
module c432_key_ctrl
  import c432_ctl_pkg::*;
#(
  parameter int               SETTLE    = 2,
  parameter logic [KEY_W-1:0] KEY_RESET = 7'h00
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            key_sen,
  input  logic            key_sdi,
  input  logic            key_clr,
  output logic [3:0]      key_p,
  output logic [2:0]      key_x,
  output logic            key_valid,
  output logic            key_err,
  input  logic            q_valid,
  output logic            q_ready,
  input  logic [PI_W-1:0] q_data,
  output logic [PI_W-1:0] dut_in,
  input  logic [PO_W-1:0] dut_out,
  output logic            r_valid,
  input  logic            r_ready,
  output logic [PO_W-1:0] r_data,
  output logic            busy
);

  q_state_e         state_q;
  q_state_e         state_d;
  logic [3:0]       settle_cnt;
  logic [KEY_W-1:0] key_q;
  logic             frame_pending;
  logic             frame_ok;
  logic [KEY_W-1:0] frame_key;
  logic             frame_take;
  logic             q_accept;

  c432_key_shifter u_shifter (
    .clk           (clk),
    .rst           (rst),
    .key_sen       (key_sen),
    .key_sdi       (key_sdi),
    .key_clr       (key_clr),
    .frame_take    (frame_take),
    .frame_pending (frame_pending),
    .frame_ok      (frame_ok),
    .frame_key     (frame_key)
  );

  // The key only changes between queries, so the netlist never sees a key swap mid-evaluation.
  assign frame_take = frame_pending && (state_q == Q_IDLE);

  // Pending frame blocks new queries, which makes a commit win over a same-cycle request.
  assign q_ready  = (state_q == Q_IDLE) && key_valid && !frame_pending;
  assign q_accept = q_valid && q_ready;
  assign r_valid  = (state_q == Q_RESP);
  assign busy     = (state_q != Q_IDLE);

  assign key_p = {key_q[P4], key_q[P3], key_q[P2], key_q[P1]};
  assign key_x = {key_q[X3], key_q[X2], key_q[X1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= Q_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      Q_IDLE:    if (q_accept) state_d = Q_SETTLE;
      Q_SETTLE:  if (settle_cnt == 4'd1) state_d = Q_CAPTURE;
      Q_CAPTURE: state_d = Q_RESP;
      Q_RESP:    if (r_ready) state_d = Q_IDLE;
      default:   state_d = Q_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q     <= KEY_RESET;
      key_valid <= 1'b0;
      key_err   <= 1'b0;
    end else if (frame_take) begin
      if (frame_ok) begin
        key_q     <= frame_key;
        key_valid <= 1'b1;
        key_err   <= 1'b0;
      end else begin
        key_err   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dut_in     <= '0;
      settle_cnt <= '0;
      r_data     <= '0;
    end else begin
      if (q_accept) begin
        dut_in     <= q_data;
        settle_cnt <= 4'(SETTLE);
      end
      if ((state_q == Q_SETTLE) && (settle_cnt != 4'd1)) begin
        settle_cnt <= settle_cnt - 4'd1;
      end
      if (state_q == Q_CAPTURE) begin
        r_data <= dut_out;
      end
    end
  end

endmodule

// File: tb/tb_c432_key_ctrl.sv
// Purpose: directed self-checking bench for c432_key_ctrl with a response scoreboard.
// Latency: checks r_valid timing relative to accept and back-to-back query spacing.
// Backpressure: exercises r_ready stalls and q_ready blocking by a pending key frame.
module tb_c432_key_ctrl;
  import c432_ctl_pkg::*;

  localparam int SETTLE = 2;

  logic            clk;
  logic            rst;
  logic            key_sen;
  logic            key_sdi;
  logic            key_clr;
  logic [3:0]      key_p;
  logic [2:0]      key_x;
  logic            key_valid;
  logic            key_err;
  logic            q_valid;
  logic            q_ready;
  logic [PI_W-1:0] q_data;
  logic [PI_W-1:0] dut_in;
  logic [PO_W-1:0] dut_out;
  logic            r_valid;
  logic            r_ready;
  logic [PO_W-1:0] r_data;
  logic            busy;

  int checks   = 0;
  int failures = 0;
  logic [PO_W-1:0] sb_q[$];

  // Stand-in for the locked netlist: any function of dut_in that exposes wrong capture data.
  function automatic logic [PO_W-1:0] model_out(input logic [PI_W-1:0] v);
    return v[6:0] ^ v[35:29] ^ 7'h55;
  endfunction

  assign dut_out = model_out(dut_in);

  c432_key_ctrl #(
    .SETTLE    (SETTLE),
    .KEY_RESET (7'h00)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_sen   (key_sen),
    .key_sdi   (key_sdi),
    .key_clr   (key_clr),
    .key_p     (key_p),
    .key_x     (key_x),
    .key_valid (key_valid),
    .key_err   (key_err),
    .q_valid   (q_valid),
    .q_ready   (q_ready),
    .q_data    (q_data),
    .dut_in    (dut_in),
    .dut_out   (dut_out),
    .r_valid   (r_valid),
    .r_ready   (r_ready),
    .r_data    (r_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [7:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      key_sdi = f[i];
      key_sen = 1'b1;
      tick();
    end
    key_sen = 1'b0;
    key_sdi = 1'b0;
  endtask

  task automatic check_key(input string tag, input logic [3:0] p, input logic [2:0] x,
                           input logic v, input logic e);
    check({tag, "_key_p"}, key_p, p);
    check({tag, "_key_x"}, key_x, x);
    check({tag, "_key_valid"}, key_valid, v);
    check({tag, "_key_err"}, key_err, e);
  endtask

  // Frames: key in [6:0], even parity in [7].
  localparam logic [7:0] FRAME_A     = 8'b0101_0011;
  localparam logic [7:0] FRAME_A_BAD = 8'b1101_0011;
  localparam logic [7:0] FRAME_B     = 8'b1010_1100;

  logic [PI_W-1:0] vec [3];
  logic [PO_W-1:0] exp_r;
  int n_acc;
  int last_acc;
  bit acc;
  bit rsp;
  bit seen;

  initial begin
    vec[0] = 36'hA_5A5A_5A5A;
    vec[1] = 36'h3_0F0F_F0F0;
    vec[2] = 36'hC_1234_9876;
    rst = 1'b1; key_sen = 1'b0; key_sdi = 1'b0; key_clr = 1'b0;
    q_valid = 1'b1; q_data = 36'h1_2345_6789; r_ready = 1'b0;

    // Reset state with a query already requested.
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_q_ready", q_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_r_valid", r_valid, 1'b0);
    check("rst_dut_in", dut_in, 36'h0);
    check("rst_r_data", r_data, 7'h00);
    check_key("rst", 4'h0, 3'h0, 1'b0, 1'b0);
    tick();
    check("nokey_no_accept_busy", busy, 1'b0);
    q_valid = 1'b0;

    // Good frame commits one edge after the 8th bit.
    shift_bits(FRAME_A, 8);
    check("pending_q_ready", q_ready, 1'b0);
    check_key("pending_a", 4'h0, 3'h0, 1'b0, 1'b0);
    tick();
    check_key("commit_a", 4'b0011, 3'b101, 1'b1, 1'b0);
    check("commit_a_q_ready", q_ready, 1'b1);

    // Bad parity flags an error and keeps the key.
    shift_bits(FRAME_A_BAD, 8);
    tick();
    check_key("bad_a", 4'b0011, 3'b101, 1'b1, 1'b1);
    check("bad_a_q_ready", q_ready, 1'b1);

    // Single query: r_valid rises SETTLE+1 edges after accept, held under stall.
    q_valid = 1'b1;
    q_data  = 36'h0;
    sb_q.push_back(model_out(q_data));
    tick();
    q_valid = 1'b0;
    check("q1_busy", busy, 1'b1);
    check("q1_dut_in", dut_in, 36'h0);
    check("q1_r_valid_e0", r_valid, 1'b0);
    tick();
    check("q1_r_valid_e1", r_valid, 1'b0);
    tick();
    check("q1_r_valid_e2", r_valid, 1'b0);
    tick();
    check("q1_r_valid_e3", r_valid, 1'b1);
    exp_r = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
    check("q1_r_data", r_data, exp_r);
    check("q1_r_data_abs", r_data, 7'h55);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("q1_stall_r_valid", r_valid, 1'b1);
      check("q1_stall_r_data", r_data, exp_r);
    end
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    check("q1_idle_busy", busy, 1'b0);
    check("q1_idle_r_valid", r_valid, 1'b0);
    check("q1_idle_q_ready", q_ready, 1'b1);

    // Back-to-back queries with r_ready held high: one every SETTLE+3 cycles.
    q_valid = 1'b1; r_ready = 1'b1; q_data = vec[0];
    n_acc = 0; last_acc = -1;
    for (int c = 0; c < 40 && (n_acc < 3 || sb_q.size() > 0); c++) begin
      acc = q_valid && q_ready;
      rsp = r_valid && r_ready;
      if (rsp) begin
        if (sb_q.size() > 0) check("tp_r_data", r_data, sb_q.pop_front());
        else check("tp_spurious_r_valid", r_valid, 1'b0);
      end
      if (acc) begin
        sb_q.push_back(model_out(q_data));
        if (n_acc > 0) check("tp_interval", 64'(c - last_acc), 64'(SETTLE + 3));
        last_acc = c;
        n_acc++;
      end
      tick();
      if (acc) begin
        if (n_acc < 3) q_data = vec[n_acc];
        else q_valid = 1'b0;
      end
    end
    r_ready = 1'b0;
    check("tp_accepts", 64'(n_acc), 64'd3);
    check("tp_sb_empty", 64'(sb_q.size()), 64'd0);
    check("tp_dut_in_hold", dut_in, vec[2]);
    check("tp_busy", busy, 1'b0);

    // Frame completes during SETTLE: key frozen until IDLE, then committed.
    shift_bits(FRAME_B, 7);
    check("b_pre_q_ready", q_ready, 1'b1);
    key_sdi = FRAME_B[7]; key_sen = 1'b1;
    q_valid = 1'b1; q_data = 36'h5_5AA5_3C3C;
    sb_q.push_back(model_out(q_data));
    tick();
    key_sen = 1'b0; key_sdi = 1'b0; q_valid = 1'b0;
    check("b_busy", busy, 1'b1);
    check("b_q_ready", q_ready, 1'b0);
    check_key("b_settle", 4'b0011, 3'b101, 1'b1, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (r_valid) seen = 1'b1;
      else begin
        check("b_wait_key_p", key_p, 4'b0011);
        tick();
      end
    end
    check("b_r_valid_seen", r_valid, 1'b1);
    exp_r = (sb_q.size() > 0) ? sb_q.pop_front() : 'x;
    check("b_r_data", r_data, exp_r);
    tick(); tick();
    check_key("b_resp", 4'b0011, 3'b101, 1'b1, 1'b1);
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    check("b_idle_busy", busy, 1'b0);
    check("b_idle_q_ready", q_ready, 1'b0);
    check_key("b_idle", 4'b0011, 3'b101, 1'b1, 1'b1);
    tick();
    check_key("b_commit", 4'b1100, 3'b010, 1'b1, 1'b0);
    check("b_commit_q_ready", q_ready, 1'b1);

    // Reset mid-query aborts; key_clr beats key_sen; next frame commits cleanly.
    q_valid = 1'b1; q_data = vec[1];
    tick();
    q_valid = 1'b0;
    tick();
    check("rq_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("rq_async_busy", busy, 1'b0);
    tick();
    rst = 1'b0;
    sb_q.delete();
    tick();
    check("rq_r_valid", r_valid, 1'b0);
    check("rq_q_ready", q_ready, 1'b0);
    check_key("rq", 4'h0, 3'h0, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (r_valid) seen = 1'b1;
      tick();
    end
    check("rq_no_resp", seen, 1'b0);
    shift_bits(8'hFF, 3);
    key_clr = 1'b1; key_sen = 1'b1; key_sdi = 1'b1;
    tick();
    key_clr = 1'b0; key_sen = 1'b0; key_sdi = 1'b0;
    shift_bits(FRAME_A, 8);
    tick();
    check_key("clr_commit", 4'b0011, 3'b101, 1'b1, 1'b0);
    check("clr_q_ready", q_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
